singleport_ram64x8_design: RTL and testbench

SINGLEPORT_RAM64X8_DESIGN -- requirements
Module: singleport_ram64x8_design

---
 rtl/singleport_ram64x8_design_if.sv | 25 ++
 rtl/singleport_ram64x8_design.sv | 46 ++++
 tb/tb_singleport_ram64x8_design.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/singleport_ram64x8_design_if.sv
// Bus bundle for the 64x8 single-port RAM: access controls, address, write data and
// registered read data. The master drives the access and the slave returns data_out.
interface singleport_ram64x8_design_if;
   logic       enable;
   logic       read;
   logic [5:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output enable,
      output read,
      output address,
      output data_in,
      input  data_out
   );

   modport slave (
      input  enable,
      input  read,
      input  address,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/singleport_ram64x8_design.sv
// 64-word x 8-bit single-port RAM with a registered read port and a synchronous clear.
// Define RAM_WRITE_THROUGH_EN so that writes also update data_out at the same edge.
module singleport_ram64x8_design (
   input logic                          clk,
   input logic                          reset,
   singleport_ram64x8_design_if.slave   bus
);
   logic [7:0] mem [64];
   logic [7:0] data_q;
   logic       do_write;
   logic       do_read;

   assign do_write = bus.enable && !bus.read;
   assign do_read  = bus.enable &&  bus.read;

   // Reset clears the whole array, so the storage cannot be inferred as a plain block RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            mem[i[5:0]] <= 8'h00;
         end
      end else if (do_write) begin
         mem[bus.address] <= bus.data_in;
      end
   end

   // Output register: it updates only on a read, or on a write in the write-through build.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= 8'h00;
      end else if (do_read) begin
         data_q <= mem[bus.address];
      end
`ifdef RAM_WRITE_THROUGH_EN
      else if (do_write) begin
         data_q <= bus.data_in;
      end
`else
      else begin
         data_q <= data_q;
      end
`endif
   end

   assign bus.data_out = data_q;
endmodule

// File: tb/tb_singleport_ram64x8_design.sv
// Scoreboard bench for singleport_ram64x8_design: directed scenarios plus random traffic,
// checked against an array-based reference model of the RAM.
module tb_singleport_ram64x8_design;
   logic clk;
   logic reset;

   singleport_ram64x8_design_if bus ();

   singleport_ram64x8_design dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] expected;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic [7:0] model_mem [64];
   logic [7:0] model_out;
   int         vectors;
   int         miscompares;
   bit         stim_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the word array and output register after one clock edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic rd,
                                input logic [5:0] addr, input logic [7:0] din,
                                input string tag);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      bus.enable  = en;
      bus.read    = rd;
      bus.address = addr;
      bus.data_in = din;
      if (rst) begin
         for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
         model_out = 8'h00;
      end else if (en && rd) begin
         model_out = model_mem[addr];
      end else if (en) begin
         model_mem[addr] = din;
`ifdef RAM_WRITE_THROUGH_EN
         model_out = din;
`endif
      end
      e.expected = model_out;
      e.tag      = tag;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input logic [7:0] actual, input logic [7:0] expected,
                              input string tag);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: data_out=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Monitor: one expected value per edge, sampled just after it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            checkOutput(bus.data_out, cur.expected, cur.tag);
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      stim_done   = 1'b0;
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.read    = 1'b0;
      bus.address = 6'd0;
      bus.data_in = 8'h00;
      model_out   = 8'h00;

      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 8'h00, "reset");
      for (int a = 0; a < 64; a++)
         applyStimulus(1'b0, 1'b1, 1'b1, 6'(a), 8'h00, "read_all_zero");

      applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 8'h01, "wr0");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd1, 8'h02, "wr1");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd2, 8'h03, "wr2");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 8'h00, "rd0");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd1, 8'h00, "rd1");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd2, 8'h00, "rd2");

      applyStimulus(1'b1, 1'b1, 1'b0, 6'd2, 8'h03, "rst_write");
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd0, 8'h00, "rst_rd0");
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd1, 8'h00, "rst_rd1");
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd2, 8'h00, "rst_rd2");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd2, 8'h00, "post_rst_rd2");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 8'h00, "post_rst_rd0");

      applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 8'hA5, "wr5");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd5, 8'h00, "rd5");
      for (int k = 0; k < 6; k++)
         applyStimulus(1'b0, 1'b0, 1'(k), 6'($urandom_range(0, 63)), 8'($urandom),
                       "idle_hold");

      applyStimulus(1'b0, 1'b1, 1'b0, 6'd1, 8'h02, "wr1_old");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd1, 8'h04, "wr1_new");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd1, 8'h00, "rd1_after_wr");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd63, 8'hFF, "wr63");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd63, 8'h00, "rd63_after_wr");

      applyStimulus(1'b0, 1'b1, 1'b1, 6'd5, 8'h00, "rd5_again");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd7, 8'h5A, "write_through");
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd7, 8'h00, "rd7");

      for (int n = 0; n < 500; n++) begin
         logic r;
         r = ($urandom_range(0, 59) == 0);
         applyStimulus(r, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                       6'($urandom_range(0, 63)), 8'($urandom), "random");
      end

      stim_done = 1'b1;
      for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
